iter_div: RTL

Iterative radix-2 integer divider: the inverse-operation companion to `booth_mult` in the execute stage's multi-cycle arithmetic unit. It services RISC-V DIV/DIVU/REM/REMU, producing quotient and remainder together. It uses the same `v_i`/`ready_o` input handshake and `v_o`/`yumi_i` output handshake as `booth_mult`, so the issue logic drives both units identically. One operation is in flight at a time; it takes a fixed multi-cycle latency, except that divide-by-zero exits early.

---
 rtl/iter_div.sv | 131 +++++++++++++
 1 files changed

// File: rtl/iter_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iter_div : iterative radix-2 restoring divider, quotient + remainder,
//            signed/unsigned, v/ready in and v/yumi out handshakes.
// Revision : 1.0
// ---------------------------------------------------------------------------
module iter_div #(
  parameter int data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [data_width_p-1:0] dividend_i,
  input  logic [data_width_p-1:0] divisor_i,
  input  logic                    signed_i,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic [data_width_p-1:0] quotient_o,
  output logic [data_width_p-1:0] remainder_o
);

  localparam int W  = data_width_p;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  dvsr_q, dvsr_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic          div_zero;
  logic          dvd_neg;
  logic          dvs_neg;
  logic [W:0]    shifted;
  logic [W+1:0]  trial;

  assign accept   = (state_q == S_IDLE) && v_i;
  assign div_zero = (divisor_i == '0);
  assign dvd_neg  = signed_i & dividend_i[W-1];
  assign dvs_neg  = signed_i & divisor_i[W-1];

  // quot_q doubles as the dividend shift register: its MSB feeds the remainder
  assign shifted = {rem_q[W-1:0], quot_q[W-1]};
  assign trial   = {rem_q, quot_q[W-1]} - {2'b00, dvsr_q};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = div_zero ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (yumi_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    cnt_d  = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (div_zero) begin
            quot_d = '1;
            rem_d  = {1'b0, dividend_i};
          end else begin
            quot_d = dvd_neg ? -dividend_i : dividend_i;
            dvsr_d = dvs_neg ? -divisor_i : divisor_i;
            qneg_d = dvd_neg ^ dvs_neg;
            rneg_d = dvd_neg;
            rem_d  = '0;
            cnt_d  = CW'(W);
          end
        end
      end
      S_CALC: begin
        cnt_d  = cnt_q - CW'(1);
        quot_d = {quot_q[W-2:0], ~trial[W+1]};
        rem_d  = trial[W+1] ? shifted : trial[W:0];
      end
      S_FIX: begin
        if (qneg_q) quot_d = -quot_q;
        if (rneg_q) rem_d = {1'b0, -rem_q[W-1:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    ready_o = (state_q == S_IDLE) && !reset_i;
    v_o     = (state_q == S_DONE);
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rem_q[W-1:0];

endmodule
`default_nettype wire
